nibble_serial_subtractor: RTL and testbench
===========================================

// Module: nibble_serial_subtractor
// PURPOSE
//  Multi-cycle WIDTH-bit subtractor: D = A - B - i_borrow, 4 bits per clock, LSB nibble first,
//  borrow rippled between nibbles through a 1-bit register. Companion to the 4-bit adder slice;
//  serves SUB/SLT/SLTU/branch compare in the execute stage where area beats latency.
//  Start/valid handshake; returns registered difference plus borrow, Z, N, V, LT, LTU flags.
// PARAMETERS
//  WIDTH   32   operand width in bits; must be a multiple of 4 and >= 8
// PORTS
//  i_clk         in   1      clock, rising edge
//  i_rst_n       in   1      asynchronous active-low reset
//  i_start       in   1      request; operands sampled on the edge where it is accepted
//  i_minuend     in   WIDTH  A
//  i_subtrahend  in   WIDTH  B
//  i_borrow      in   1      borrow-in (1 subtracts an extra 1)
//  o_busy        out  1      operation in progress
//  o_valid       out  1      one-cycle pulse: result outputs just updated
//  o_diff        out  WIDTH  A - B - i_borrow, modulo 2^WIDTH
//  o_borrow      out  1      borrow out of MSB (1 = unsigned underflow)
//  o_zero        out  1      o_diff == 0
//  o_neg         out  1      o_diff[WIDTH-1]
//  o_ovf         out  1      signed overflow
//  o_lt          out  1      signed A < B (o_neg ^ o_ovf)
//  o_ltu         out  1      unsigned A < B (= o_borrow)
// BEHAVIOUR
//  Reset (i_rst_n low, async): state IDLE, nibble counter 0, all outputs and working regs 0.
//  FSM: IDLE, BUSY. N = WIDTH/4.
//   IDLE: i_start=1 at an edge -> latch A, B, carry = ~i_borrow into working regs, cnt=0, -> BUSY.
//   BUSY: each edge computes nibble cnt: {c,d} = A[4cnt+:4] + ~B[4cnt+:4] + carry;
//     working diff nibble <= d, carry <= c, cnt++. Edge at cnt==N-1 -> IDLE.
//  Completion (edge at cnt==N-1): o_diff, o_borrow=~c, flags loaded in one shot; o_valid=1
//   for exactly the next cycle. Results hold unchanged until the next completion.
//  Timing: i_start high in cycle 0 -> o_busy high cycles 1..N -> o_valid high in cycle N+1
//   (WIDTH=32: o_valid in cycle 9). o_busy = (state==BUSY), combinational from state.
//  o_ovf = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]), A/B/D from the latched operation.
//  i_borrow enters only the lowest nibble; it is not included in the overflow equation beyond
//   its effect on D.
//  Boundaries:
//   - i_start while BUSY: ignored, no queueing; inputs may change freely while BUSY.
//   - i_start in the o_valid cycle (state IDLE): accepted; back-to-back ops every N+1 cycles.
//   - Reset mid-operation: op aborted, no o_valid, outputs return to 0 immediately.
//   - Operands/flags never partially visible: o_diff changes only at completion.
//   - Full borrow chain (e.g. 0x10000000 - 1) must propagate across all N nibbles.
// TESTING
//  5 - 3, bin=0 -> o_valid cycle 9; diff=0x00000002, borrow=0, Z=0,N=0,V=0,LT=0,LTU=0.
//  0 - 1 -> diff=0xFFFFFFFF, borrow=1, N=1, V=0, LT=1, LTU=1; then 5-3 bin=1 -> diff=1.
//  0x80000000 - 1 -> diff=0x7FFFFFFF, V=1, N=0, LT=1, LTU=0; 0x10000000-1 -> 0x0FFFFFFF.
//  0x12345678 - 0x12345678 -> diff=0, Z=1, borrow=0, LT=0, LTU=0.
//  i_start pulsed in cycles 3,5 of a busy op -> ignored, single o_valid; new start in the
//   o_valid cycle -> accepted, second o_valid exactly 9 cycles later.
//  i_rst_n low in cycle 4 of an op -> all outputs 0 at once, no o_valid; next op correct.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - multi-cycle subtractor, one nibble per clock, LSB first
module nibble_serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_minuend,
  input  logic [WIDTH-1:0] i_subtrahend,
  input  logic             i_borrow,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_ovf,
  output logic             o_lt,
  output logic             o_ltu
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, work_q, work_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic [4:0]       nib_sum;
  logic             last;

  // Operands shift right each step, so the active nibble is always at [3:0]
  // and on the final step a_q[3]/b_q[3] are the original sign bits.
  always_comb begin
    nib_sum  = {1'b0, a_q[3:0]} + {1'b0, ~b_q[3:0]} + {4'b0000, carry_q};
    last     = (cnt_q == CW'(N - 1));
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    carry_d  = carry_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          a_d     = i_minuend;
          b_d     = i_subtrahend;
          carry_d = ~i_borrow;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        work_d  = {nib_sum[3:0], work_q[WIDTH-1:4]};
        carry_d = nib_sum[4];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d  = IDLE;
          cnt_d    = '0;
          diff_d   = work_d;
          borrow_d = ~nib_sum[4];
          zero_d   = (work_d == '0);
          neg_d    = work_d[WIDTH-1];
          ovf_d    = (a_q[3] != b_q[3]) && (work_d[WIDTH-1] != a_q[3]);
          valid_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      carry_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      carry_q  <= carry_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign o_busy   = (state_q == BUSY);
  assign o_valid  = valid_q;
  assign o_diff   = diff_q;
  assign o_borrow = borrow_q;
  assign o_zero   = zero_q;
  assign o_neg    = neg_q;
  assign o_ovf    = ovf_q;
  assign o_lt     = neg_q ^ ovf_q;
  assign o_ltu    = borrow_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - directed bench for nibble_serial_subtractor
module tb_nibble_serial_subtractor;

  logic        clk, rst_n, start, bin;
  logic [31:0] a, b;
  logic        busy, valid, borrow, zero, neg, ovf, lt, ltu;
  logic [31:0] diff;
  int          total, passed, cyc, nvalid, vcyc;

  nibble_serial_subtractor #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_minuend(a), .i_subtrahend(b), .i_borrow(bin),
    .o_busy(busy), .o_valid(valid), .o_diff(diff), .o_borrow(borrow),
    .o_zero(zero), .o_neg(neg), .o_ovf(ovf), .o_lt(lt), .o_ltu(ltu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // flags packed as {borrow, zero, neg, ovf, lt, ltu}
  task automatic check_result(input string tag, input logic [31:0] ed, input logic [5:0] ef);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_flags"}, {26'd0, borrow, zero, neg, ovf, lt, ltu}, {26'd0, ef});
  endtask

  // called one time unit after an edge; returns one time unit after the accepting edge
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int c);
    c = 1;
    while (!valid && c < 30) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  initial begin
    total = 0; passed = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {busy, valid, borrow, zero, neg, ovf, lt, ltu}, 32'd0);
    check("reset_diff", diff, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    start_op(32'd5, 32'd3, 1'b0);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_valid(cyc);
    check("lat_5m3", cyc, 32'd9);
    check_result("5m3", 32'h2, 6'b000000);
    @(posedge clk); #1;
    check("valid_pulse_end", {31'd0, valid}, 32'd0);
    check("hold_diff", diff, 32'h2);

    start_op(32'd0, 32'd1, 1'b0);
    wait_valid(cyc);
    check_result("0m1", 32'hFFFF_FFFF, 6'b101011);

    start_op(32'd5, 32'd3, 1'b1);
    wait_valid(cyc);
    check_result("5m3b1", 32'h1, 6'b000000);

    start_op(32'h8000_0000, 32'd1, 1'b0);
    wait_valid(cyc);
    check_result("min_m1", 32'h7FFF_FFFF, 6'b000110);

    start_op(32'h1000_0000, 32'd1, 1'b0);
    wait_valid(cyc);
    check_result("chain", 32'h0FFF_FFFF, 6'b000000);

    start_op(32'h1234_5678, 32'h1234_5678, 1'b0);
    wait_valid(cyc);
    check_result("equal", 32'h0, 6'b010000);

    // start pulses in cycles 3 and 5 of a busy op must be ignored
    start_op(32'd100, 32'd1, 1'b0);
    cyc = 1; nvalid = 0; vcyc = 0;
    repeat (12) begin
      start = (cyc == 3 || cyc == 5);
      if (start) begin a = 32'd0; b = 32'd7; end
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (valid) begin nvalid++; vcyc = cyc; end
    end
    check("ignored_nvalid", nvalid, 32'd1);
    check("ignored_vcyc", vcyc, 32'd9);
    check("ignored_diff", diff, 32'h63);

    // back-to-back: new start in the o_valid cycle
    start_op(32'd7, 32'd2, 1'b0);
    wait_valid(cyc);
    check_result("b2b_first", 32'h5, 6'b000000);
    start_op(32'd20, 32'd5, 1'b0);
    wait_valid(cyc);
    check("b2b_lat", cyc, 32'd9);
    check_result("b2b_second", 32'hF, 6'b000000);

    // reset in cycle 4 of an op
    start_op(32'h1234, 32'h1, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {busy, valid, borrow, zero, neg, ovf, lt, ltu}, 32'd0);
    check("midrst_diff", diff, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nvalid = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    check("midrst_novalid", nvalid, 32'd0);
    start_op(32'd9, 32'd4, 1'b0);
    wait_valid(cyc);
    check("postrst_lat", cyc, 32'd9);
    check_result("postrst", 32'h5, 6'b000000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
